// File: rtl/branch_cond_unit.sv
// branch_cond_unit
// Holds the 3-bit ALU status word (N, V, Z) and resolves one conditional-branch
// request at a time against it. A request is accepted in IDLE, evaluated in EVAL
// against the status register as it stands in that cycle, and its result is
// presented in RESP until the consumer accepts it.
//
// Optional build macro: BRANCH_STATS_EN
//   When defined, the unit also exports saturating 16-bit counters of taken and
//   not-taken results (illegal conditions count as not taken).
module branch_cond_unit #(
  parameter int PC_W  = 9,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       alu_status,
  input  logic             load_s,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  pc_in,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic             illegal,
  output logic [PC_W-1:0]  next_pc,
  output logic [2:0]       status_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]      taken_cnt,
  output logic [15:0]      not_taken_cnt
`endif
);

  // Condition encodings
  localparam logic [2:0] COND_B   = 3'b000;
  localparam logic [2:0] COND_BEQ = 3'b001;
  localparam logic [2:0] COND_BNE = 3'b010;
  localparam logic [2:0] COND_BLT = 3'b011;
  localparam logic [2:0] COND_BLE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t state_q, state_d;

  // Latched request fields
  logic [2:0]       cond_q, cond_d;
  logic [IMM_W-1:0] imm_q, imm_d;
  logic [PC_W-1:0]  pc_q, pc_d;

  // Registered result
  logic             taken_q, taken_d;
  logic             illegal_q, illegal_d;
  logic [PC_W-1:0]  next_pc_q, next_pc_d;

  // Status register next value
  logic [2:0]       status_d;

  // Combinational evaluation of the latched request
  logic             flag_n, flag_v, flag_z;
  logic             eval_taken, eval_illegal;
  logic [PC_W-1:0]  imm_ext;
  logic [PC_W-1:0]  pc_plus1;
  logic [PC_W-1:0]  pc_target;

  assign flag_n = status_q[0];
  assign flag_v = status_q[1];
  assign flag_z = status_q[2];

  // Sign-extend (or truncate) the word offset to the PC width.
  generate
    if (PC_W > IMM_W) begin : g_imm_sext
      assign imm_ext = {{(PC_W - IMM_W){imm_q[IMM_W-1]}}, imm_q};
    end else begin : g_imm_trunc
      assign imm_ext = imm_q[PC_W-1:0];
    end
  endgenerate

  // Both sums wrap naturally at PC_W bits.
  assign pc_plus1  = pc_q + PC_W'(1);
  assign pc_target = pc_plus1 + imm_ext;

  // Handshake outputs come straight from the state.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);

  assign taken   = taken_q;
  assign illegal = illegal_q;
  assign next_pc = next_pc_q;

  // Status register: loads whenever load_s is high, regardless of FSM state.
  always_comb begin
    status_d = status_q;
    if (load_s) begin
      status_d = alu_status;
    end
  end

  // Status register storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= 3'b000;
    end else begin
      status_q <= status_d;
    end
  end

  // Next-state logic for the request FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register; reset discards any in-flight request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture request fields only on acceptance so later input changes are ignored.
  always_comb begin
    cond_d = cond_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      cond_d = cond;
      imm_d  = imm;
      pc_d   = pc_in;
    end
  end

  // Request field storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q <= 3'b000;
      imm_q  <= '0;
      pc_q   <= '0;
    end else begin
      cond_q <= cond_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
    end
  end

  // Decode the latched condition against the current status flags.
  always_comb begin
    eval_taken   = 1'b0;
    eval_illegal = 1'b0;
    case (cond_q)
      COND_B:   eval_taken = 1'b1;
      COND_BEQ: eval_taken = flag_z;
      COND_BNE: eval_taken = ~flag_z;
      COND_BLT: eval_taken = flag_n ^ flag_v;
      COND_BLE: eval_taken = (flag_n ^ flag_v) | flag_z;
      default: begin
        eval_taken   = 1'b0;
        eval_illegal = 1'b1;
      end
    endcase
  end

  // Result registers update only in EVAL and otherwise hold their last value.
  always_comb begin
    taken_d   = taken_q;
    illegal_d = illegal_q;
    next_pc_d = next_pc_q;
    if (state_q == ST_EVAL) begin
      taken_d   = eval_taken;
      illegal_d = eval_illegal;
      next_pc_d = eval_taken ? pc_target : pc_plus1;
    end
  end

  // Result storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      next_pc_q <= '0;
    end else begin
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      next_pc_q <= next_pc_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] not_taken_cnt_q, not_taken_cnt_d;

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;

  // Count each result once, on the EVAL->RESP transition, saturating at all-ones.
  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (state_q == ST_EVAL) begin
      if (eval_taken) begin
        if (taken_cnt_q != 16'hFFFF) begin
          taken_cnt_d = taken_cnt_q + 16'd1;
        end
      end else begin
        if (not_taken_cnt_q != 16'hFFFF) begin
          not_taken_cnt_d = not_taken_cnt_q + 16'd1;
        end
      end
    end
  end

  // Statistics counter storage; cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt_q     <= 16'd0;
      not_taken_cnt_q <= 16'd0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: directed vector table plus randomized
// requests checked against an arithmetic reference model.
module tb_branch_cond_unit;

  localparam int PC_W  = 9;
  localparam int IMM_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [2:0]       alu_status;
  logic             load_s;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       cond;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  pc_in;
  logic             resp_valid;
  logic             resp_ready;
  logic             taken;
  logic             illegal;
  logic [PC_W-1:0]  next_pc;
  logic [2:0]       status_q;
`ifdef BRANCH_STATS_EN
  logic [15:0]      taken_cnt;
  logic [15:0]      not_taken_cnt;
`endif

  always #5 clk = ~clk;

  branch_cond_unit #(.PC_W(PC_W), .IMM_W(IMM_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_status (alu_status),
    .load_s     (load_s),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .cond       (cond),
    .imm        (imm),
    .pc_in      (pc_in),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .taken      (taken),
    .illegal    (illegal),
    .next_pc    (next_pc),
    .status_q   (status_q)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
`endif
  );

  int cmp_count  = 0;
  int fail_count = 0;

  logic [2:0] model_status;
  int         model_taken_n;
  int         model_not_taken_n;

  typedef struct {
    bit         pre_ld;
    logic [2:0] pre_st;
    bit         acc_ld;
    logic [2:0] acc_st;
    bit         ev_ld;
    logic [2:0] ev_st;
    logic [2:0] c;
    logic [7:0] im;
    logic [8:0] pc;
    int         hold;
    bit         e_tk;
    bit         e_il;
    logic [8:0] e_pc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: branch rules applied with plain integer arithmetic.
  function automatic void model_eval(input logic [2:0] st, input logic [2:0] c,
                                     input logic [7:0] im, input logic [8:0] pc,
                                     output bit tk, output bit il, output logic [8:0] npc);
    bit n, v, z;
    int off, target;
    n = st[0]; v = st[1]; z = st[2];
    il = 1'b0;
    case (c)
      3'd0: tk = 1'b1;
      3'd1: tk = z;
      3'd2: tk = !z;
      3'd3: tk = (n != v);
      3'd4: tk = (n != v) || z;
      default: begin tk = 1'b0; il = 1'b1; end
    endcase
    off    = (int'(im) >= 128) ? int'(im) - 256 : int'(im);
    target = int'(pc) + 1 + (tk ? off : 0);
    target = ((target % 512) + 512) % 512;
    npc    = target[8:0];
  endfunction

  function automatic vec_t mkv(input bit pl, input logic [2:0] ps, input bit al, input logic [2:0] as,
                               input bit el, input logic [2:0] es, input logic [2:0] c,
                               input logic [7:0] im, input logic [8:0] pc, input int hold,
                               input bit tk, input bit il, input logic [8:0] npc);
    vec_t v;
    v.pre_ld = pl; v.pre_st = ps; v.acc_ld = al; v.acc_st = as;
    v.ev_ld = el; v.ev_st = es; v.c = c; v.im = im; v.pc = pc; v.hold = hold;
    v.e_tk = tk; v.e_il = il; v.e_pc = npc;
    return v;
  endfunction

  // Runs one request through the full handshake and checks every phase.
  task automatic run_req(input string tag, input vec_t v);
    int waited;
    if (v.pre_ld) begin
      @(negedge clk);
      alu_status = v.pre_st;
      load_s     = 1'b1;
      @(negedge clk);
      load_s       = 1'b0;
      model_status = v.pre_st;
      check({tag, " pre_status"}, 32'(status_q), 32'(model_status));
    end
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " req_ready_wait"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    cond      = v.c;
    imm       = v.im;
    pc_in     = v.pc;
    if (v.acc_ld) begin
      alu_status   = v.acc_st;
      load_s       = 1'b1;
      model_status = v.acc_st;
    end
    @(negedge clk);  // accept edge has passed: unit is in EVAL
    req_valid = 1'b0;
    load_s    = 1'b0;
    cond      = 3'($urandom);
    imm       = 8'($urandom);
    pc_in     = 9'($urandom);
    check({tag, " eval_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " eval_req_ready"}, 32'(req_ready), 32'd0);
    if (v.ev_ld) begin
      alu_status = v.ev_st;
      load_s     = 1'b1;
    end
    @(negedge clk);  // second edge after accept: result presented
    load_s = 1'b0;
    if (v.ev_ld) model_status = v.ev_st;
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " taken"}, 32'(taken), 32'(v.e_tk));
    check({tag, " illegal"}, 32'(illegal), 32'(v.e_il));
    check({tag, " next_pc"}, 32'(next_pc), 32'(v.e_pc));
    for (int i = 0; i < v.hold; i++) begin
      req_valid = 1'b1;
      cond      = 3'($urandom);
      pc_in     = 9'($urandom);
      @(negedge clk);
      check({tag, " hold_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, " hold_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, " hold_next_pc"}, 32'(next_pc), 32'(v.e_pc));
      check({tag, " hold_taken"}, 32'(taken), 32'(v.e_tk));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " done_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " done_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " done_next_pc_held"}, 32'(next_pc), 32'(v.e_pc));
    check({tag, " status_q"}, 32'(status_q), 32'(model_status));
    if (v.e_tk) model_taken_n++;
    else        model_not_taken_n++;
    $display("%s: cond=%0d pc=%03h imm=%02h -> taken=%0b illegal=%0b next_pc=%03h (exp %0b %0b %03h)",
             tag, v.c, v.pc, v.im, taken, illegal, next_pc, v.e_tk, v.e_il, v.e_pc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    logic [2:0] eff;
    bit tk, il;
    logic [8:0] npc;

    model_status      = 3'b000;
    model_taken_n     = 0;
    model_not_taken_n = 0;

    vecs[0]  = mkv(1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 3'b001, 8'h05, 9'h010, 0, 1'b1, 1'b0, 9'h016);
    vecs[1]  = mkv(1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000, 3'b011, 8'hF0, 9'h020, 0, 1'b1, 1'b0, 9'h011);
    vecs[2]  = mkv(1'b1, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000, 3'b011, 8'hF0, 9'h020, 0, 1'b0, 1'b0, 9'h021);
    vecs[3]  = mkv(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b110, 8'h33, 9'h1FF, 0, 1'b0, 1'b1, 9'h000);
    vecs[4]  = mkv(1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 8'h7F, 9'h100, 5, 1'b1, 1'b0, 9'h180);
    vecs[5]  = mkv(1'b1, 3'b000, 1'b1, 3'b100, 1'b0, 3'b000, 3'b010, 8'h10, 9'h050, 0, 1'b0, 1'b0, 9'h051);
    vecs[6]  = mkv(1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 3'b100, 3'b010, 8'h10, 9'h050, 0, 1'b1, 1'b0, 9'h061);
    vecs[7]  = mkv(1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 3'b100, 8'hFE, 9'h030, 0, 1'b1, 1'b0, 9'h02F);
    vecs[8]  = mkv(1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000, 3'b100, 8'h20, 9'h1F0, 0, 1'b1, 1'b0, 9'h011);
    vecs[9]  = mkv(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b100, 8'h20, 9'h030, 0, 1'b0, 1'b0, 9'h031);
    vecs[10] = mkv(1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000, 3'b101, 8'h01, 9'h000, 1, 1'b0, 1'b1, 9'h001);
    vecs[11] = mkv(1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 3'b000, 3'b111, 8'h01, 9'h00A, 0, 1'b0, 1'b1, 9'h00B);
    vecs[12] = mkv(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b001, 8'h80, 9'h002, 0, 1'b0, 1'b0, 9'h003);
    vecs[13] = mkv(1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 8'h80, 9'h002, 2, 1'b1, 1'b0, 9'h183);

    reset_n    = 1'b0;
    alu_status = 3'b000;
    load_s     = 1'b0;
    req_valid  = 1'b0;
    cond       = 3'b000;
    imm        = '0;
    pc_in      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset status_q", 32'(status_q), 32'd0);
    check("reset taken", 32'(taken), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset next_pc", 32'(next_pc), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_req($sformatf("vec%0d", i), vecs[i]);
    end

    for (int i = 0; i < 40; i++) begin
      rv.pre_ld = 1'($urandom);
      rv.pre_st = 3'($urandom);
      rv.acc_ld = 1'($urandom);
      rv.acc_st = 3'($urandom);
      rv.ev_ld  = 1'($urandom);
      rv.ev_st  = 3'($urandom);
      rv.c      = 3'($urandom);
      rv.im     = 8'($urandom);
      rv.pc     = 9'($urandom);
      rv.hold   = int'($urandom_range(0, 2));
      eff = rv.acc_ld ? rv.acc_st : (rv.pre_ld ? rv.pre_st : model_status);
      model_eval(eff, rv.c, rv.im, rv.pc, tk, il, npc);
      rv.e_tk = tk;
      rv.e_il = il;
      rv.e_pc = npc;
      run_req($sformatf("rand%0d", i), rv);
    end

`ifdef BRANCH_STATS_EN
    check("taken_cnt", 32'(taken_cnt), 32'(model_taken_n));
    check("not_taken_cnt", 32'(not_taken_cnt), 32'(model_not_taken_n));
`endif

    // Asynchronous reset while a response is pending.
    @(negedge clk);
    alu_status = 3'b111;
    load_s     = 1'b1;
    req_valid  = 1'b1;
    cond       = 3'b000;
    imm        = 8'h04;
    pc_in      = 9'h040;
    @(negedge clk);
    load_s    = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset resp_valid", 32'(resp_valid), 32'd1);
    check("pre_reset next_pc", 32'(next_pc), 32'h045);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset resp_valid", 32'(resp_valid), 32'd0);
    check("async_reset req_ready", 32'(req_ready), 32'd1);
    check("async_reset status_q", 32'(status_q), 32'd0);
    check("async_reset taken", 32'(taken), 32'd0);
    check("async_reset next_pc", 32'(next_pc), 32'd0);
    $display("async_reset: resp_valid=%0b req_ready=%0b status_q=%03b", resp_valid, req_ready, status_q);
    @(negedge clk);
    reset_n      = 1'b1;
    model_status = 3'b000;
    @(negedge clk);
    check("post_reset resp_valid", 32'(resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
    $finish;
  end

endmodule
